melody_player: RTL

Plays a stored note sequence on the piezo for one round of the memory game. It sits downstream of `play_music`: when `start` pulses, it walks the sequence memory from index 0 up to `length`-1. For each entry it sounds a square-wave tone with a matching LED, then a silent gap. It pulses `done` at the end, which lets the round controller hand over to player input.

---
 rtl/melody_player.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/melody_player.sv
// Plays one round of the memory-game sequence: each stored note sounds as a
// square wave with a one-hot LED for NOTE_TICKS cycles, followed by a silent gap of GAP_TICKS cycles.
module melody_player #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int NOTE_TICKS = 25_000_000,
  parameter int GAP_TICKS  = 5_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] length,
  input  logic [2:0] note_code,
  output logic [3:0] note_index,
  output logic       busy,
  output logic       piezo,
  output logic [6:0] led,
  output logic       done,
  output logic [2:0] dbg_state
);

  localparam int H1 = CLK_HZ / (2 * 262);
  localparam int H2 = CLK_HZ / (2 * 294);
  localparam int H3 = CLK_HZ / (2 * 330);
  localparam int H4 = CLK_HZ / (2 * 349);
  localparam int H5 = CLK_HZ / (2 * 392);
  localparam int H6 = CLK_HZ / (2 * 440);
  localparam int H7 = CLK_HZ / (2 * 494);

  // C4 has the longest half-period, so it sets the phase counter width.
  localparam int PW   = $clog2(H1 + 1);
  localparam int MAXT = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int TW   = $clog2(MAXT + 1);

  localparam logic [TW-1:0] NOTE_LAST = TW'(NOTE_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state_q;
  logic [4:0]    len_q;
  logic [3:0]    note_index_q;
  logic [2:0]    cur_q;
  logic [TW-1:0] tick_q;
  logic [PW-1:0] phase_q;
  logic          busy_q;
  logic          piezo_q;
  logic [6:0]    led_q;
  logic          done_q;

  function automatic logic [PW-1:0] half_last(input logic [2:0] code);
    logic [PW-1:0] r;
    case (code)
      3'd1:    r = PW'(H1 - 1);
      3'd2:    r = PW'(H2 - 1);
      3'd3:    r = PW'(H3 - 1);
      3'd4:    r = PW'(H4 - 1);
      3'd5:    r = PW'(H5 - 1);
      3'd6:    r = PW'(H6 - 1);
      3'd7:    r = PW'(H7 - 1);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] onehot(input logic [2:0] code);
    return (code == 3'd0) ? 7'd0 : 7'(7'd1 << (code - 3'd1));
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      note_index_q <= '0;
      cur_q        <= '0;
      tick_q       <= '0;
      phase_q      <= '0;
      busy_q       <= 1'b0;
      piezo_q      <= 1'b0;
      led_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q       <= 1'b1;
            note_index_q <= '0;
            len_q        <= (length > 5'd16) ? 5'd16 : length;
            if (length == 5'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          // Memory has had a full cycle to follow note_index; capture now.
          cur_q   <= note_code;
          tick_q  <= '0;
          phase_q <= '0;
          led_q   <= onehot(note_code);
          piezo_q <= 1'b0;
          state_q <= PLAY;
        end
        PLAY: begin
          if (tick_q == NOTE_LAST) begin
            tick_q  <= '0;
            led_q   <= '0;
            piezo_q <= 1'b0;
            state_q <= GAP;
          end else begin
            tick_q <= tick_q + TW'(1);
            if (cur_q != 3'd0) begin
              if (phase_q == half_last(cur_q)) begin
                phase_q <= '0;
                piezo_q <= ~piezo_q;
              end else begin
                phase_q <= phase_q + PW'(1);
              end
            end
          end
        end
        GAP: begin
          if (tick_q == GAP_LAST) begin
            tick_q <= '0;
            if ({1'b0, note_index_q} == len_q - 5'd1) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              note_index_q <= note_index_q + 4'd1;
              state_q      <= LOAD;
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign note_index = note_index_q;
  assign busy       = busy_q;
  assign piezo      = piezo_q;
  assign led        = led_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule
